// File: rtl/qsys_sysid_pkg.sv
// Shared constants for the extended system-ID slave: the register map,
// CONTROL bit positions and the CAPS field layout.
package qsys_sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
  localparam logic [2:0] ADDR_CONTROL   = 3'd5;
  localparam logic [2:0] ADDR_CAPS      = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int CAPS_LAT_LSB   = 0;
  localparam int CAPS_WIDTH_LSB = 8;

  // CAPS word: {16'h0, uptime width, 4'h0, read latency}
  function automatic logic [31:0] capsWord(input int upWidth, input int rdLatency);
    logic [31:0] w;
    w = '0;
    w[CAPS_WIDTH_LSB +: 8] = 8'(upWidth);
    w[CAPS_LAT_LSB +: 4]   = 4'(rdLatency);
    return w;
  endfunction

endpackage

// File: rtl/qsys_sysid_rd_pipe.sv
// Fixed-latency read response pipeline. Each stage carries a valid flag and
// the word sampled at acceptance; the last stage drives the response.
module qsys_sysid_rd_pipe
  import qsys_sysid_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] data_o
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];

  // Shift every stage down by one, new sample enters stage 0
  always_comb begin
    valid_d[0] = valid_i;
    data_d[0]  = data_i;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Stage registers; reset flushes any in-flight response
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;

endmodule

// File: rtl/qsys_sysid_ext.sv
// Extended system-ID Avalon-MM slave: ID/timestamp, scratch register,
// free-running uptime counter with coherent LO/HI read, control and caps.
module qsys_sysid_ext
  import qsys_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'd1539279297,
  parameter int          UPTIME_WIDTH    = 64,
  parameter int          READ_LATENCY    = 1,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int HI_W = UPTIME_WIDTH - 32;
  localparam logic [UPTIME_WIDTH-1:0] UPTIME_ONE = 1;

  logic [31:0]             scratch_q, scratch_d;
  logic                    enable_q, enable_d;
  logic [UPTIME_WIDTH-1:0] uptime_q, uptime_d;
  logic [HI_W-1:0]         hiSnap_q, hiSnap_d;
  logic [31:0]             rdWord;
  logic [31:0]             rdSample;
  logic                    ctrlWrite;

  // Read mux over the current register state (read-before-write)
  always_comb begin
    rdWord = '0;
    case (address)
      ADDR_ID:        rdWord = ID_VALUE;
      ADDR_TIMESTAMP: rdWord = TIMESTAMP_VALUE;
      ADDR_SCRATCH:   rdWord = scratch_q;
      ADDR_UPTIME_LO: rdWord = uptime_q[31:0];
      ADDR_UPTIME_HI: rdWord = 32'(hiSnap_q);
      ADDR_CONTROL:   rdWord = {31'b0, enable_q};
      ADDR_CAPS:      rdWord = capsWord(UPTIME_WIDTH, READ_LATENCY);
      default:        rdWord = '0;
    endcase
  end

  // Next state for scratch, control, uptime counter and the high-word snapshot
  always_comb begin
    scratch_d = scratch_q;
    if (write && (address == ADDR_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch_d[8*i +: 8] = writedata[8*i +: 8];
        end
      end
    end

    ctrlWrite = write && (address == ADDR_CONTROL) && byteenable[0];
    enable_d  = ctrlWrite ? writedata[CTRL_EN] : enable_q;

    uptime_d = uptime_q;
    if (ctrlWrite && writedata[CTRL_CLR]) begin
      uptime_d = '0;
    end else if (enable_q) begin
      uptime_d = uptime_q + UPTIME_ONE;
    end

    hiSnap_d = hiSnap_q;
    if (read && (address == ADDR_UPTIME_LO)) begin
      hiSnap_d = uptime_q[UPTIME_WIDTH-1:32];
    end
  end

  // Register file state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= SCRATCH_RESET;
      enable_q  <= 1'b1;
      uptime_q  <= '0;
      hiSnap_q  <= '0;
    end else begin
      scratch_q <= scratch_d;
      enable_q  <= enable_d;
      uptime_q  <= uptime_d;
      hiSnap_q  <= hiSnap_d;
    end
  end

  assign rdSample = read ? rdWord : '0;

  qsys_sysid_rd_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clock_i  (clock),
    .reset_ni (reset_n),
    .valid_i  (read),
    .data_i   (rdSample),
    .valid_o  (readdatavalid),
    .data_o   (readdata)
  );

endmodule

// File: tb/tb_qsys_sysid_ext.sv
// Directed self-checking bench for qsys_sysid_ext with READ_LATENCY=3.
module tb_qsys_sysid_ext;

  localparam int          LAT  = 3;
  localparam logic [31:0] ID   = 32'h1234_5678;
  localparam logic [31:0] TS   = 32'd1539279297;
  localparam logic [31:0] SRST = 32'h5A5A_0F0F;
  // CAPS = {16'h0, 8'd64, 4'h0, 4'd3}
  localparam logic [31:0] CAPS = 32'h0000_4003;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  qsys_sysid_ext #(
    .ID_VALUE        (ID),
    .TIMESTAMP_VALUE (TS),
    .UPTIME_WIDTH    (64),
    .READ_LATENCY    (LAT),
    .SCRATCH_RESET   (SRST)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  rsp_t rspQ[$];
  int   cycleCount  = 0;
  int   checkCount  = 0;
  int   passCount   = 0;
  int   idleNonZero = 0;
  int   lastReqCyc  = 0;

  // Cycle index, bumped on every active edge
  always @(posedge clock) cycleCount++;

  // Collect responses on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (readdatavalid) begin
      rspQ.push_back('{data: readdata, cyc: cycleCount});
    end else if (readdata != 32'h0) begin
      idleNonZero++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    read       = rd;
    write      = wr;
    address    = addr;
    writedata  = wdata;
    byteenable = be;
    lastReqCyc = cycleCount;
    tick();
    read       = 1'b0;
    write      = 1'b0;
    address    = 3'd0;
    writedata  = 32'h0;
    byteenable = 4'h0;
  endtask

  task automatic waitRsp(input string tag, output rsp_t r);
    int budget;
    budget = 0;
    while (rspQ.size() == 0 && budget < 20) begin
      tick();
      budget++;
    end
    if (rspQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL %s: no readdatavalid within 20 cycles, expected a response", tag);
      r.data = 32'hDEAD_BEEF;
      r.cyc  = -1;
    end else begin
      r = rspQ.pop_front();
    end
  endtask

  task automatic readCheck(input string tag, input logic [2:0] addr, input logic [31:0] expected);
    rsp_t r;
    int   req;
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0);
    req = lastReqCyc;
    waitRsp(tag, r);
    checkOutput(tag, 64'(r.data), 64'(expected));
    checkOutput({tag, "_lat"}, 64'(r.cyc - req), 64'(LAT));
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(1'b0, 1'b1, addr, data, be);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rsp_t r0, r1, r2, r3;
    int   req0;
    int   clrCyc;
    int   frozen;

    reset_n    = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = 3'd0;
    writedata  = 32'h0;
    byteenable = 4'h0;
    repeat (3) tick();
    checkOutput("reset_valid", 64'(readdatavalid), 64'd0);
    checkOutput("reset_rdata", 64'(readdata), 64'd0);
    reset_n = 1'b1;
    tick();

    // ID read: exactly one response, LAT cycles after the read cycle
    readCheck("id", 3'd0, ID);
    repeat (4) tick();
    checkOutput("id_single_rsp", 64'(rspQ.size()), 64'd0);

    // Back-to-back reads of TIMESTAMP, CAPS, reserved
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h0, 4'h0);
    req0 = lastReqCyc;
    applyStimulus(1'b1, 1'b0, 3'd6, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 3'd7, 32'h0, 4'h0);
    waitRsp("b2b_0", r0);
    waitRsp("b2b_1", r1);
    waitRsp("b2b_2", r2);
    checkOutput("b2b_ts", 64'(r0.data), 64'(TS));
    checkOutput("b2b_caps", 64'(r1.data), 64'(CAPS));
    checkOutput("b2b_rsvd", 64'(r2.data), 64'd0);
    checkOutput("b2b_lat", 64'(r0.cyc - req0), 64'(LAT));
    checkOutput("b2b_gap1", 64'(r1.cyc - r0.cyc), 64'd1);
    checkOutput("b2b_gap2", 64'(r2.cyc - r1.cyc), 64'd1);

    // Scratch: reset value, byte lanes, read-before-write
    readCheck("scratch_reset", 3'd2, SRST);
    writeReg(3'd2, 32'h0, 4'hF);
    writeReg(3'd2, 32'hAABB_CCDD, 4'b0101);
    readCheck("scratch_lanes", 3'd2, 32'h00BB_00DD);
    applyStimulus(1'b1, 1'b1, 3'd2, 32'h1122_3344, 4'hF);
    waitRsp("scratch_rbw", r0);
    checkOutput("scratch_rbw", 64'(r0.data), 64'h00BB_00DD);
    readCheck("scratch_new", 3'd2, 32'h1122_3344);
    writeReg(3'd4, 32'hFFFF_FFFF, 4'hF);
    readCheck("ro_hi_unchanged", 3'd4, 32'h0);

    // Control: clear while enabled restarts at 0, then counts up
    readCheck("ctrl_reset", 3'd5, 32'h1);
    writeReg(3'd5, 32'h3, 4'h1);
    clrCyc = lastReqCyc;
    readCheck("upt_after_clr", 3'd3, 32'h0);
    repeat (3) tick();
    readCheck("upt_running", 3'd3, 32'(cycleCount - clrCyc - 1));
    readCheck("ctrl_rb_en", 3'd5, 32'h1);

    // Freeze: the edge that disables still increments once
    writeReg(3'd5, 32'h0, 4'hF);
    frozen = lastReqCyc - clrCyc;
    readCheck("upt_frozen_a", 3'd3, 32'(frozen));
    repeat (10) tick();
    readCheck("upt_frozen_b", 3'd3, 32'(frozen));
    writeReg(3'd5, 32'h3, 4'b1110);
    readCheck("ctrl_be0", 3'd5, 32'h0);
    readCheck("upt_be0", 3'd3, 32'(frozen));

    // Coherent LO/HI across a carry out of bit 31
    writeReg(3'd5, 32'h1, 4'h1);
    force dut.uptime_d = 64'h0000_0000_FFFF_FFFF;
    tick();
    release dut.uptime_d;
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
    repeat (4) tick();
    applyStimulus(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
    waitRsp("coh_0", r0);
    waitRsp("coh_1", r1);
    waitRsp("coh_2", r2);
    waitRsp("coh_3", r3);
    checkOutput("coh_lo_first", 64'(r0.data), 64'hFFFF_FFFF);
    checkOutput("coh_hi_first", 64'(r1.data), 64'h0);
    checkOutput("coh_lo_second", 64'(r2.data), 64'h5);
    checkOutput("coh_hi_second", 64'(r3.data), 64'h1);

    // Reset one cycle after a read: the response is discarded
    checkOutput("q_empty_pre_reset", 64'(rspQ.size()), 64'd0);
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    checkOutput("no_rsp_after_reset", 64'(rspQ.size()), 64'd0);
    readCheck("scratch_after_reset", 3'd2, SRST);
    readCheck("ctrl_after_reset", 3'd5, 32'h1);
    readCheck("hi_after_reset", 3'd4, 32'h0);

    checkOutput("idle_rdata_zero", 64'(idleNonZero), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
